// File: rtl/tff_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop counter.
package tff_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int unsigned MAX_WIDTH = 32'd32;

  // Loads above the last count value are pinned to MODULUS-1.
  function automatic logic [MAX_WIDTH-1:0] clamp_load(
    input logic [MAX_WIDTH-1:0] value,
    input logic [MAX_WIDTH:0]   modulus
  );
    logic [MAX_WIDTH:0] lastVal;
    lastVal = modulus - {{MAX_WIDTH{1'b0}}, 1'b1};
    if ({1'b0, value} > lastVal) begin
      return lastVal[MAX_WIDTH-1:0];
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/tff_counter_cell.sv
// One-bit T flip-flop with synchronous active-low reset.
module tff_sync_cell (
  input  logic clk,
  input  logic resetN,
  input  logic T,
  output logic Q,
  output logic notQ
);

  // Toggle state when T is high.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      Q <= 1'b0;
    end else begin
      Q <= Q ^ T;
    end
  end

  assign notQ = ~Q;

endmodule

// File: rtl/tff_counter.sv
// Modulus counter built from T flip-flop cells; supports load and saturate.
// Down counting is compiled in only when TFF_COUNTER_DOWN_EN is defined.
module tff_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             tc,
  output logic             wrapped
);
  import tff_counter_pkg::*;

  if (WIDTH < 32'd1 || WIDTH > MAX_WIDTH || MODULUS < 64'd2 ||
      MODULUS > (64'd1 << WIDTH)) begin : gParamCheck
    $error("tff_counter: WIDTH must be 1..32 and MODULUS 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]     TERM_EXT = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0]   TERM     = WIDTH'(MODULUS - 64'd1);
  localparam logic [MAX_WIDTH:0] MOD_EXT  = (MAX_WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] qInt;
  logic [WIDTH-1:0] notQInt;
  logic [WIDTH-1:0] nextQ;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] upNext;
  logic [WIDTH-1:0] stepNext;
  logic [WIDTH-1:0] termSel;
  logic             upWrap;
  logic             stepWrap;
  logic             wrapNext;
  logic             wrappedReg;

  // Up-count successor, compared at WIDTH+1 bits so MODULUS=2**WIDTH is safe.
  always_comb begin
    upNext = qInt;
    upWrap = 1'b0;
    if ({1'b0, qInt} >= TERM_EXT) begin
      if (SATURATE) begin
        upNext = qInt;
        upWrap = 1'b0;
      end else begin
        upNext = {WIDTH{1'b0}};
        upWrap = 1'b1;
      end
    end else begin
      upNext = WIDTH'({1'b0, qInt} + (WIDTH+1)'(1'b1));
      upWrap = 1'b0;
    end
  end

`ifdef TFF_COUNTER_DOWN_EN
  logic [WIDTH-1:0] dnNext;
  logic             dnWrap;

  // Down-count successor.
  always_comb begin
    dnNext = qInt;
    dnWrap = 1'b0;
    if (qInt == {WIDTH{1'b0}}) begin
      if (SATURATE) begin
        dnNext = qInt;
        dnWrap = 1'b0;
      end else begin
        dnNext = TERM;
        dnWrap = 1'b1;
      end
    end else begin
      dnNext = qInt - WIDTH'(1'b1);
      dnWrap = 1'b0;
    end
  end

  // Direction select for the step value and the terminal compare.
  always_comb begin
    stepNext = upNext;
    stepWrap = upWrap;
    termSel  = TERM;
    if (down == DIR_DOWN) begin
      stepNext = dnNext;
      stepWrap = dnWrap;
      termSel  = {WIDTH{1'b0}};
    end else begin
      stepNext = upNext;
      stepWrap = upWrap;
      termSel  = TERM;
    end
  end
`else
  logic unusedDown;
  assign unusedDown = down;
  assign stepNext   = upNext;
  assign stepWrap   = upWrap;
  assign termSel    = TERM;
`endif

  // Priority: load, then count, then hold (reset lives in the flops).
  always_comb begin
    nextQ    = qInt;
    wrapNext = 1'b0;
    if (load) begin
      nextQ    = WIDTH'(clamp_load(MAX_WIDTH'(loadValue), MOD_EXT));
      wrapNext = 1'b0;
    end else if (en) begin
      nextQ    = stepNext;
      wrapNext = stepWrap;
    end else begin
      nextQ    = qInt;
      wrapNext = 1'b0;
    end
  end

  assign toggle = qInt ^ nextQ;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    tff_sync_cell uCell (
      .clk    (clk),
      .resetN (resetN),
      .T      (toggle[i]),
      .Q      (qInt[i]),
      .notQ   (notQInt[i])
    );
  end

  // One-cycle wrap pulse.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wrappedReg <= 1'b0;
    end else begin
      wrappedReg <= wrapNext;
    end
  end

  assign Q       = qInt;
  assign notQ    = notQInt;
  assign tc      = en & ~load & (qInt == termSel);
  assign wrapped = wrappedReg;

endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench: three 4-bit counters (mod 10 wrap, mod 10 saturate,
// mod 16 default) against an arithmetic reference model.
module tb_tff_counter;
  import tff_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN, en, down, load;
  logic [3:0] loadValue;
  logic [2:0][3:0] qA, nqA;
  logic [2:0] tcA, wrA;

  int vectors = 0;
  int miscompares = 0;

  int  modA [3] = '{10, 10, 16};
  bit  satA [3] = '{1'b0, 1'b1, 1'b0};
  int  mq   [3];
  bit  mw   [3];
  bit  mValid = 1'b0;

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u0 (
    .clk(clk), .resetN(resetN), .en(en), .down(down), .load(load),
    .loadValue(loadValue), .Q(qA[0]), .notQ(nqA[0]), .tc(tcA[0]), .wrapped(wrA[0]));
  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u1 (
    .clk(clk), .resetN(resetN), .en(en), .down(down), .load(load),
    .loadValue(loadValue), .Q(qA[1]), .notQ(nqA[1]), .tc(tcA[1]), .wrapped(wrA[1]));
  tff_counter #(.WIDTH(4)) u2 (
    .clk(clk), .resetN(resetN), .en(en), .down(down), .load(load),
    .loadValue(loadValue), .Q(qA[2]), .notQ(nqA[2]), .tc(tcA[2]), .wrapped(wrA[2]));

  function automatic bit dirDown();
`ifdef TFF_COUNTER_DOWN_EN
    return down;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string nm, input int k, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[u%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!resetN) begin
        mq[k] = 0; mw[k] = 1'b0;
      end else if (load) begin
        mq[k] = int'(clamp_load(32'(loadValue), 33'(modA[k]))); mw[k] = 1'b0;
      end else if (en && !dirDown()) begin
        if (mq[k] == modA[k] - 1) begin
          mw[k] = !satA[k];
          if (!satA[k]) mq[k] = 0;
        end else begin
          mq[k] = mq[k] + 1; mw[k] = 1'b0;
        end
      end else if (en) begin
        if (mq[k] == 0) begin
          mw[k] = !satA[k];
          if (!satA[k]) mq[k] = modA[k] - 1;
        end else begin
          mq[k] = mq[k] - 1; mw[k] = 1'b0;
        end
      end else begin
        mw[k] = 1'b0;
      end
    end
    if (!resetN) mValid = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mValid) begin
      for (int k = 0; k < 3; k++) begin
        check("Q", k, qA[k], mq[k]);
        check("notQ", k, nqA[k], 15 - mq[k]);
        check("tc", k, tcA[k], (en && !load && mq[k] == (dirDown() ? 0 : modA[k] - 1)) ? 1 : 0);
        check("wrapped", k, wrA[k], mw[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; en = 1'b0; down = 1'b0; load = 1'b0; loadValue = 4'd0;
    step(); step();
    check("lit_reset_q", 0, qA[0], 0);
    check("lit_reset_wr", 0, wrA[0], 0);

    // Reset beats load and enable.
    resetN = 1'b1; load = 1'b1; loadValue = 4'd9;
    step();
    check("lit_load9", 0, qA[0], 9);
    resetN = 1'b0; en = 1'b1;
    step();
    check("lit_rst_over_load", 0, qA[0], 0);
    check("lit_rst_wr", 0, wrA[0], 0);

    // Up count with wrap.
    resetN = 1'b1; load = 1'b0;
    #1;
    check("lit_tc_at0", 0, tcA[0], 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("lit_up_q", 0, qA[0], i % 10);
      check("lit_up_wr", 0, wrA[0], (i == 10) ? 1 : 0);
      check("lit_up_tc", 0, tcA[0], (i == 9) ? 1 : 0);
    end

    // Saturation.
    load = 1'b1; loadValue = 4'd8;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_sat_q", 1, qA[1], 9);
      check("lit_sat_wr", 1, wrA[1], 0);
      check("lit_sat_tc", 1, tcA[1], 1);
    end

    // Down from 1.
    load = 1'b1; loadValue = 4'd1;
    step();
    load = 1'b0; down = 1'b1;
    step();
`ifdef TFF_COUNTER_DOWN_EN
    check("lit_down_q0", 0, qA[0], 0);
    step();
    check("lit_down_q9", 0, qA[0], 9);
    check("lit_down_wr", 0, wrA[0], 1);
`else
    check("lit_down_q2", 0, qA[0], 2);
    step();
    check("lit_down_q3", 0, qA[0], 3);
`endif

    // Load beats enable, with clamping.
    down = 1'b0; load = 1'b1; loadValue = 4'd15;
    step();
    check("lit_clamp", 0, qA[0], 9);
    check("lit_noclamp16", 2, qA[2], 15);
    load = 1'b0;
    #1;
    check("lit_tc_pre_wrap", 0, tcA[0], 1);
    check("lit_tc_rollover", 2, tcA[2], 1);
    step();
    check("lit_wrap_q", 0, qA[0], 0);
    check("lit_wrap_wr", 0, wrA[0], 1);
    check("lit_roll_q", 2, qA[2], 0);
    check("lit_roll_wr", 2, wrA[2], 1);

    // Hold.
    load = 1'b1; loadValue = 4'd5;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lit_hold_q", 0, qA[0], 5);
      check("lit_hold_nq", 0, nqA[0], 4'b1010);
      check("lit_hold_tc", 0, tcA[0], 0);
    end

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      resetN    = ($urandom_range(0, 31) != 0);
      en        = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 7) == 0);
      down      = $urandom_range(0, 1) == 1;
      loadValue = 4'($urandom_range(0, 15));
      step();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
